// File: rtl/uart_tx_buffered_pkg.sv
// uart_tx_buffered_pkg: shared state encoding and frame constants for the UART transmitter
package uart_tx_buffered_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int DEFAULT_CLK = 16;
endpackage

// File: rtl/uart_tx_buffered_fifo.sv
// uart_tx_buffered_fifo: synchronous FIFO with combinational head and occupancy count
module uart_tx_buffered_fifo #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2,
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [W-1:0]      din,
  output logic [W-1:0]      dout,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);
  localparam int CW = ADDR_W + 1;
  logic [W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  // pointers wrap naturally at DEPTH; count tracks push minus pop
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + ADDR_W'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + ADDR_W'(1) : rd_ptr;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered 8N1 UART transmitter
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLK = DEFAULT_CLK,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 2
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              TX_VALID,
  input  logic [7:0]        TX_PARALLEL,
  output logic              TX_READY,
  output logic              TX_SERIAL,
  output logic              TX_ACTIVE,
  output logic              DONE,
  output logic [ADDR_W:0]   FIFO_COUNT
);
  localparam int CNT_W = $clog2(CLK);
  tx_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n, head;
  logic serial_n, active_n, done_n, pop, push, full, empty, last, last_bit;
  assign TX_READY = !RESET && !full;
  assign push = TX_VALID && TX_READY;
  assign last = cnt == CNT_W'(CLK - 1);
  assign last_bit = bit_idx == 3'(UART_DATA_BITS - 1);
  uart_tx_buffered_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .W(8)) u_fifo (
    .clk(CLOCK),
    .rst(RESET),
    .push(push),
    .pop(pop),
    .din(TX_PARALLEL),
    .dout(head),
    .count(FIFO_COUNT),
    .full(full),
    .empty(empty)
  );
  // frame sequencing: each phase lasts CLK cycles, line value is registered on transition
  always_comb begin
    state_n = state;
    cnt_n = last ? '0 : cnt + CNT_W'(1);
    bit_n = bit_idx;
    shift_n = shift;
    serial_n = TX_SERIAL;
    active_n = TX_ACTIVE;
    done_n = 1'b0;
    pop = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        serial_n = empty;
        active_n = !empty;
        pop = !empty;
        shift_n = empty ? shift : head;
        state_n = empty ? IDLE : START;
      end
      START: if (last) begin
        state_n = DATA;
        serial_n = shift[0];
        bit_n = '0;
      end
      DATA: if (last) begin
        shift_n = shift >> 1;
        serial_n = last_bit ? 1'b1 : shift[1];
        bit_n = bit_idx + 3'd1;
        state_n = last_bit ? STOP : DATA;
      end
      STOP: if (last) begin
        state_n = IDLE;
        active_n = 1'b0;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any frame and idles the line high
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      TX_SERIAL <= 1'b1;
      TX_ACTIVE <= 1'b0;
      DONE <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      TX_SERIAL <= serial_n;
      TX_ACTIVE <= active_n;
      DONE <= done_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: scoreboard bench with a serial receiver model on the line
module tb_uart_tx_buffered;
  logic CLOCK = 0, RESET = 1, v = 0, v4 = 0;
  logic [7:0] d = 0, d4 = 0;
  logic rdy, ser, act, done, rdy4, ser4, act4, done4;
  logic [2:0] cnt, cnt4;
  int cyc = 0, total = 0, bad = 0, done_cnt = 0, frame_err = 0, e0 = 0;
  logic [7:0] exp_q[$], rx_q[$];
  int start_q[$];

  uart_tx_buffered #(.CLK(16), .DEPTH(4), .ADDR_W(2)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .TX_VALID(v), .TX_PARALLEL(d), .TX_READY(rdy),
    .TX_SERIAL(ser), .TX_ACTIVE(act), .DONE(done), .FIFO_COUNT(cnt));
  uart_tx_buffered #(.CLK(4), .DEPTH(4), .ADDR_W(2)) dut4 (
    .CLOCK(CLOCK), .RESET(RESET), .TX_VALID(v4), .TX_PARALLEL(d4), .TX_READY(rdy4),
    .TX_SERIAL(ser4), .TX_ACTIVE(act4), .DONE(done4), .FIFO_COUNT(cnt4));

  always #5 CLOCK = ~CLOCK;
  always @(posedge CLOCK) cyc++;

  function automatic logic exp_ser(int n, int c, logic [7:0] b);
    int j;
    j = (n - 1) / c;
    return (j == 0) ? 1'b0 : (j <= 8) ? b[j-1] : 1'b1;
  endfunction

  // receiver model: mid-bit sampling of the CLK=16 line, aborted by reset
  initial begin
    int c;
    logic busy;
    logic [7:0] sh;
    busy = 0; c = 0; sh = 0;
    forever begin
      @(negedge CLOCK);
      if (done) done_cnt++;
      if (RESET) busy = 0;
      else if (!busy) begin
        if (!ser) begin busy = 1; c = 0; start_q.push_back(cyc); end
      end else begin
        c++;
        if (c == 8 && ser) frame_err++;
        if (c >= 24 && c <= 136 && (c - 8) % 16 == 0) sh = {ser, sh[7:1]};
        if (c == 152) begin
          if (!ser) frame_err++;
          rx_q.push_back(sh);
          busy = 0;
        end
      end
    end
  end

  task automatic test_reset();
    RESET = 1;
    repeat (3) @(negedge CLOCK);
    total++;
    if (rdy !== 0 || rdy4 !== 0) begin bad++; $display("FAIL ready_in_reset: got %b/%b want 0/0", rdy, rdy4); end
    total++;
    if (ser !== 1 || act !== 0 || done !== 0 || cnt !== 0) begin
      bad++; $display("FAIL reset_state: ser=%b act=%b done=%b cnt=%0d want 1 0 0 0", ser, act, done, cnt);
    end
    RESET = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK);
      total++;
      if (ser !== 1 || done !== 0 || act !== 0 || ser4 !== 1) begin
        bad++; $display("FAIL idle_%0d: ser=%b done=%b act=%b ser4=%b want 1 0 0 1", i, ser, done, act, ser4);
      end
    end
    total++;
    if (rdy !== 1 || cnt !== 0 || rdy4 !== 1) begin
      bad++; $display("FAIL idle_ready: rdy=%b cnt=%0d rdy4=%b want 1 0 1", rdy, cnt, rdy4);
    end
  endtask

  task automatic test_single();
    int d0;
    logic [7:0] got, want;
    d0 = done_cnt;
    v = 1; d = 8'hAB;
    total++;
    if (rdy !== 1) begin bad++; $display("FAIL single_ready: got %b want 1", rdy); end
    exp_q.push_back(8'hAB);
    @(negedge CLOCK);
    v = 0; d = 8'h00;
    total++;
    if (cnt !== 1) begin bad++; $display("FAIL single_count0: got %0d want 1", cnt); end
    for (int n = 1; n <= 161; n++) begin
      @(negedge CLOCK);
      total++;
      if (ser !== exp_ser(n, 16, 8'hAB) || act !== (n <= 160) || done !== (n == 161)) begin
        bad++; $display("FAIL single_cycle_%0d: ser=%b act=%b done=%b want %b %b %b",
                        n, ser, act, done, exp_ser(n, 16, 8'hAB), n <= 160, n == 161);
      end
      if (n == 1) begin
        total++;
        if (cnt !== 0) begin bad++; $display("FAIL single_count1: got %0d want 0", cnt); end
      end
    end
    repeat (20) @(negedge CLOCK);
    total++;
    if (done_cnt !== d0 + 1) begin bad++; $display("FAIL single_done_pulses: got %0d want %0d", done_cnt - d0, 1); end
    total++;
    if (rx_q.size() == 0) begin bad++; $display("FAIL single_rx: got no byte want 8'hab"); end
    else begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL single_rx: got %h want %h", got, want); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb[5];
    int ec[5];
    bb = '{8'h00, 8'hFF, 8'h55, 8'hE7, 8'h12};
    ec = '{0, 1, 1, 2, 3};
    for (int i = 0; i < 5; i++) begin
      v = 1; d = bb[i];
      total++;
      if (rdy !== 1 || cnt !== ec[i]) begin
        bad++; $display("FAIL b2b_write_%0d: rdy=%b cnt=%0d want 1 %0d", i, rdy, cnt, ec[i]);
      end
      exp_q.push_back(bb[i]);
      @(negedge CLOCK);
      if (i == 0) e0 = cyc;
    end
    v = 1; d = 8'h77;
    total++;
    if (rdy !== 0 || cnt !== 4) begin bad++; $display("FAIL b2b_sixth_refused: rdy=%b cnt=%0d want 0 4", rdy, cnt); end
  endtask

  task automatic test_full_pop();
    int s0, d0;
    logic [7:0] got, want;
    s0 = start_q.size() - 1;
    d0 = done_cnt;
    while (cyc < e0 + 161) begin
      @(negedge CLOCK);
      total++;
      if (rdy !== 0 || cnt !== 4) begin bad++; $display("FAIL full_hold_%0d: rdy=%b cnt=%0d want 0 4", cyc - e0, rdy, cnt); end
    end
    @(negedge CLOCK);
    total++;
    if (rdy !== 1 || cnt !== 3) begin bad++; $display("FAIL full_after_pop: rdy=%b cnt=%0d want 1 3", rdy, cnt); end
    exp_q.push_back(8'h77);
    @(negedge CLOCK);
    v = 0;
    total++;
    if (rdy !== 0 || cnt !== 4) begin bad++; $display("FAIL full_refilled: rdy=%b cnt=%0d want 0 4", rdy, cnt); end
    for (int i = 0; i < 6 * 161 + 100 && rx_q.size() < 6; i++) @(negedge CLOCK);
    repeat (20) @(negedge CLOCK);
    total++;
    if (rx_q.size() < 6) begin bad++; $display("FAIL b2b_rx_count: got %0d want 6", rx_q.size()); end
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_rx_byte: got %h want %h", got, want); end
    end
    total++;
    if (s0 < 0 || start_q.size() < s0 + 6 || start_q[s0] !== e0 + 1) begin
      bad++; $display("FAIL b2b_first_start: got %0d want %0d", (s0 >= 0) ? start_q[s0] : -1, e0 + 1);
    end else begin
      for (int i = 1; i < 6; i++) begin
        total++;
        if (start_q[s0+i] - start_q[s0+i-1] !== 161) begin
          bad++; $display("FAIL b2b_start_gap_%0d: got %0d want 161", i, start_q[s0+i] - start_q[s0+i-1]);
        end
      end
    end
    total++;
    if (done_cnt - d0 !== 6) begin bad++; $display("FAIL b2b_done_pulses: got %0d want 6", done_cnt - d0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, r0;
    logic [7:0] got, want;
    v = 1; d = 8'h3C;
    total++;
    if (rdy !== 1) begin bad++; $display("FAIL rst_mid_ready: got %b want 1", rdy); end
    @(negedge CLOCK);
    v = 0;
    repeat (70) @(negedge CLOCK);
    total++;
    if (ser !== exp_ser(70, 16, 8'h3C) || act !== 1) begin
      bad++; $display("FAIL rst_mid_bit3: ser=%b act=%b want %b 1", ser, act, exp_ser(70, 16, 8'h3C));
    end
    d0 = done_cnt; r0 = rx_q.size();
    RESET = 1;
    @(negedge CLOCK);
    total++;
    if (ser !== 1 || act !== 0 || cnt !== 0 || done !== 0 || rdy !== 0) begin
      bad++; $display("FAIL rst_mid_state: ser=%b act=%b cnt=%0d done=%b rdy=%b want 1 0 0 0 0", ser, act, cnt, done, rdy);
    end
    RESET = 0;
    repeat (200) @(negedge CLOCK);
    total++;
    if (done_cnt !== d0 || rx_q.size() !== r0 || ser !== 1) begin
      bad++; $display("FAIL rst_mid_quiet: done=%0d rx=%0d ser=%b want 0 0 1", done_cnt - d0, rx_q.size() - r0, ser);
    end
    v = 1; d = 8'hA5;
    exp_q.push_back(8'hA5);
    @(negedge CLOCK);
    v = 0;
    for (int i = 0; i < 400 && rx_q.size() == r0; i++) @(negedge CLOCK);
    total++;
    if (rx_q.size() == r0) begin bad++; $display("FAIL rst_mid_rx: got no byte want 8'ha5"); end
    else begin
      got = rx_q.pop_front(); want = exp_q.pop_front();
      if (got !== want) begin bad++; $display("FAIL rst_mid_rx: got %h want %h", got, want); end
    end
  endtask

  task automatic test_clk4();
    v4 = 1; d4 = 8'hE7;
    total++;
    if (rdy4 !== 1) begin bad++; $display("FAIL clk4_ready: got %b want 1", rdy4); end
    @(negedge CLOCK);
    v4 = 0;
    for (int n = 1; n <= 41; n++) begin
      @(negedge CLOCK);
      total++;
      if (ser4 !== exp_ser(n, 4, 8'hE7) || act4 !== (n <= 40) || done4 !== (n == 41)) begin
        bad++; $display("FAIL clk4_cycle_%0d: ser=%b act=%b done=%b want %b %b %b",
                        n, ser4, act4, done4, exp_ser(n, 4, 8'hE7), n <= 40, n == 41);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full_pop();
    test_reset_mid_frame();
    test_clk4();
    repeat (20) @(negedge CLOCK);
    total++;
    if (frame_err !== 0 || exp_q.size() !== 0) begin
      bad++; $display("FAIL framing: errors=%0d leftover=%0d want 0 0", frame_err, exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
